// File: rtl/hazard_scoreboard_if.sv
// Decode/hazard bundle between the decode register and the scoreboard.
// master: drives instr_d/valid_d; slave: returns enables, bubble, status.
interface hazard_scoreboard_if;
  logic [31:0] instr_d;
  logic        valid_d;
  logic        en_f;
  logic        en_d;
  logic        bubble_e;
  logic        busy;
  logic [15:0] stall_cnt;

  modport master (
    output instr_d, valid_d,
    input  en_f, en_d, bubble_e, busy, stall_cnt
  );

  modport slave (
    input  instr_d, valid_d,
    output en_f, en_d, bubble_e, busy, stall_cnt
  );
endinterface

// File: rtl/hazard_scoreboard.sv
// Register scoreboard: per-register writeback countdowns plus a branch
// countdown; stalls PC/decode and bubbles execute. Ports: clk, reset, hz.
module hazard_scoreboard #(
  parameter int unsigned WB_LAT = 3,
  parameter int unsigned BR_LAT = 2
) (
  input  logic clk,
  input  logic reset,
  hazard_scoreboard_if.slave hz
);

  localparam logic [2:0] WB = 3'(WB_LAT);
  localparam logic [2:0] BR = 3'(BR_LAT);

  logic [2:0]  sb [32];
  logic [2:0]  bc;
  logic [15:0] cnt;

  logic [5:0] op;
  logic [4:0] rs, rt, rd;
  logic [4:0] dest;
  logic       use_rs, use_rt, is_br;
  logic       data_hz, stall, issue;
  logic       busy_c;
  logic       unused;

  assign op = hz.instr_d[31:26];
  assign rs = hz.instr_d[25:21];
  assign rt = hz.instr_d[20:16];
  assign rd = hz.instr_d[15:11];
  assign unused = ^hz.instr_d[10:0];

  always_comb begin
    dest   = 5'd0;
    use_rs = 1'b0;
    use_rt = 1'b0;
    is_br  = 1'b0;
    unique case (1'b1)
      (op == 6'h00): begin
        dest = rd; use_rs = 1'b1; use_rt = 1'b1;
      end
      (op == 6'h23): begin
        dest = rt; use_rs = 1'b1;
      end
      (op == 6'h2B): begin
        use_rs = 1'b1; use_rt = 1'b1;
      end
      (op == 6'h08), (op == 6'h0A),
      (op == 6'h0C), (op == 6'h0D): begin
        dest = rt; use_rs = 1'b1;
      end
      (op == 6'h0F): dest = rt;
      (op == 6'h04), (op == 6'h05): begin
        use_rs = 1'b1; use_rt = 1'b1; is_br = 1'b1;
      end
      (op == 6'h02): is_br = 1'b1;
      (op == 6'h03): begin
        dest = 5'd31; is_br = 1'b1;
      end
      default: ;
    endcase
  end

  // sb[0] is pinned to zero, so $0 sources never hazard.
  assign data_hz = (use_rs && sb[rs] != 3'd0)
                || (use_rt && sb[rt] != 3'd0);
  assign stall = hz.valid_d & (data_hz | (bc != 3'd0));
  assign issue = hz.valid_d & ~stall;

  assign hz.en_f     = ~reset & ~stall;
  assign hz.en_d     = ~reset & ~stall;
  assign hz.bubble_e = reset | ~issue;

  always_comb begin
    busy_c = (bc != 3'd0);
    for (int i = 0; i < 32; i++)
      busy_c = busy_c | (sb[i] != 3'd0);
  end

  assign hz.busy      = busy_c;
  assign hz.stall_cnt = cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 32; i++)
        sb[i] <= 3'd0;
      bc  <= 3'd0;
      cnt <= 16'd0;
    end else begin
      sb[0] <= 3'd0;
      // A fresh load wins over the decrement (WAW re-load).
      for (int i = 1; i < 32; i++) begin
        if (issue && dest == 5'(i))
          sb[i] <= WB;
        else if (sb[i] != 3'd0)
          sb[i] <= sb[i] - 3'd1;
      end
      if (issue && is_br)
        bc <= BR;
      else if (bc != 3'd0)
        bc <= bc - 3'd1;
      if (stall && cnt != 16'hFFFF)
        cnt <= cnt + 16'd1;
    end
  end

endmodule
